// File: rtl/matrix_multiply_core3x3_core_bus_write_single_if.sv
// Request and system-bus signal bundle for the core-to-bus single-word write master.
// The master modport is the write block; the slave modport is the core/bus side.
interface matrix_multiply_core3x3_core_bus_write_single_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_sel;
    logic              bus_wen;
    logic              bus_ack;
    logic              bus_err;

    modport master (
        input  req_valid, req_addr, req_data, bus_ack, bus_err,
        output req_ready, bus_addr, bus_wdata, bus_sel, bus_wen
    );

    modport slave (
        output req_valid, req_addr, req_data, bus_ack, bus_err,
        input  req_ready, bus_addr, bus_wdata, bus_sel, bus_wen
    );
endinterface

// File: rtl/matrix_multiply_core3x3_core_bus_write_single.sv
// Single-outstanding write master: takes one core write request, issues one bus write,
// waits for ack/err or timeout, then pulses done with a sticky status code.
module matrix_multiply_core3x3_core_bus_write_single #(
    parameter int         ADDR_W  = 32,
    parameter int         TIMEOUT = 255,
    parameter logic [3:0] SEL     = 4'hF
) (
    input  logic system1000,
    input  logic system1000_rst,
    matrix_multiply_core3x3_core_bus_write_single_if.master bif,
    output logic       done,
    output logic [1:0] status,
    output logic       busy
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        status_q, status_d;
    logic              req_ready_q, req_ready_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic       accept;
    logic       resp;
    logic [1:0] resp_status;

    assign accept = bif.req_valid & req_ready_q;
    assign resp   = bif.bus_ack | bif.bus_err;

    // Error outranks ack; with neither present the only way into DONE is the timeout.
    assign resp_status = bif.bus_err ? ST_BUS_ERR : (bif.bus_ack ? ST_OK : ST_TIMEOUT);

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            status_q    <= ST_OK;
            req_ready_q <= 1'b0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            status_q    <= status_d;
            req_ready_q <= req_ready_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    addr_d  = bif.req_addr;
                    wdata_d = bif.req_data;
                end
            end
            S_ISSUE: begin
                if (resp) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_ACK: begin
                if (resp || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        wen_d       = (state_d == S_ISSUE);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        status_d    = (state_d == S_DONE) ? resp_status : status_q;
    end

    assign bif.req_ready = req_ready_q;
    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;
    assign bif.bus_sel   = SEL;
    assign bif.bus_wen   = wen_q;
    assign done          = done_q;
    assign status        = status_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_matrix_multiply_core3x3_core_bus_write_single.sv
// Directed bench for the core-to-bus write master with a cycle-timeline reference model.
module tb_matrix_multiply_core3x3_core_bus_write_single;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done;
    logic [1:0] status;
    logic       busy;

    always #5 clk = ~clk;

    matrix_multiply_core3x3_core_bus_write_single_if #(.ADDR_W(ADDR_W)) bif ();

    matrix_multiply_core3x3_core_bus_write_single #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .SEL    (4'hF)
    ) u_dut (
        .system1000    (clk),
        .system1000_rst(rst),
        .bif           (bif),
        .done          (done),
        .status        (status),
        .busy          (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Timeline model: a transaction is described by its accept cycle and its done cycle.
    int          acc_cyc  = -100;
    int          done_cyc = -100;
    int          rst_from = 1;
    int          rst_to   = 1 << 30;
    logic [1:0]  st_old   = 2'b00;
    logic [1:0]  st_new   = 2'b00;
    logic [31:0] addr_old = '0;
    logic [31:0] addr_new = '0;
    logic [31:0] data_old = '0;
    logic [31:0] data_new = '0;

    int done_pulses   = 0;
    int wen_pulses    = 0;
    int last_done_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        int          c;
        bit          in_rst;
        bit          in_txn;
        logic        exp_wen;
        logic        exp_done;
        logic [1:0]  exp_st;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        c = cyc;
        if (c >= 1) begin
            in_rst   = (c >= rst_from) && (c <= rst_to);
            in_txn   = !in_rst && (c >= acc_cyc + 1) && (c <= done_cyc);
            exp_wen  = !in_rst && (c == acc_cyc + 1);
            exp_done = !in_rst && (c == done_cyc);
            exp_st   = in_rst ? 2'b00 : ((c >= done_cyc) ? st_new : st_old);
            exp_a    = in_rst ? 32'h0 : ((c >= acc_cyc + 1) ? addr_new : addr_old);
            exp_d    = in_rst ? 32'h0 : ((c >= acc_cyc + 1) ? data_new : data_old);
            chk("req_ready", bif.req_ready, !in_rst && !in_txn);
            chk("busy",      busy,          in_txn);
            chk("bus_wen",   bif.bus_wen,   exp_wen);
            chk("done",      done,          exp_done);
            chk("status",    status,        exp_st);
            chk("bus_addr",  bif.bus_addr,  exp_a);
            chk("bus_wdata", bif.bus_wdata, exp_d);
            chk("bus_sel",   bif.bus_sel,   4'hF);
            if (done === 1'b1) begin
                done_pulses++;
                last_done_cyc = c;
            end
            if (bif.bus_wen === 1'b1) wen_pulses++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        #1;
    endtask

    // Response d cycles after the wen cycle; d <= TIMEOUT lands before the abort.
    task automatic txn(input logic [31:0] a, input logic [31:0] dat, input int d,
                       input bit resp_ack, input bit resp_err);
        int c;
        int resp_c;
        c = cyc;
        st_old   = (c >= done_cyc) ? st_new : st_old;
        addr_old = addr_new;
        data_old = data_new;
        acc_cyc  = c;
        addr_new = a;
        data_new = dat;
        if ((resp_ack || resp_err) && d <= TIMEOUT) begin
            done_cyc = c + 2 + d;
            st_new   = resp_err ? 2'b01 : 2'b00;
        end else begin
            done_cyc = c + 2 + TIMEOUT;
            st_new   = 2'b10;
        end
        resp_c = c + 1 + d;
        bif.req_valid = 1'b1;
        bif.req_addr  = a;
        bif.req_data  = dat;
        tick();
        while (cyc < done_cyc + 1) begin
            bif.req_valid = 1'b1;
            bif.req_addr  = $urandom;
            bif.req_data  = $urandom;
            bif.bus_ack   = (cyc == resp_c) ? resp_ack : 1'b0;
            bif.bus_err   = (cyc == resp_c) ? resp_err : 1'b0;
            tick();
        end
        bif.req_valid = 1'b0;
        bif.bus_ack   = 1'b0;
        bif.bus_err   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_data  = '0;
        bif.bus_ack   = 1'b0;
        bif.bus_err   = 1'b0;

        // Reset held, then released; ready rises one cycle after release.
        repeat (3) tick();
        chk("t1_ready_in_rst", bif.req_ready, 1'b0);
        rst    = 1'b0;
        rst_to = cyc;
        tick();
        chk("t1_ready_after", bif.req_ready, 1'b1);
        chk("t1_status", status, 2'b00);

        // Same-cycle ack.
        d0 = done_pulses; w0 = wen_pulses;
        txn(32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
        chk("t2_done_latency", 64'(last_done_cyc - acc_cyc), 64'd2);
        chk("t2_wen_pulses", 64'(wen_pulses - w0), 64'd1);
        chk("t2_done_pulses", 64'(done_pulses - d0), 64'd1);
        chk("t2_addr", bif.bus_addr, 32'h4000_0010);
        chk("t2_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
        tick();

        // Ack five cycles after wen.
        txn(32'h4000_0020, 32'h1234_5678, 5, 1'b1, 1'b0);
        chk("t3_done_latency", 64'(last_done_cyc - acc_cyc), 64'd7);
        chk("t3_status", status, 2'b00);

        // Error and ack together two cycles after wen.
        d0 = done_pulses;
        txn(32'h4000_0030, 32'hCAFE_F00D, 2, 1'b1, 1'b1);
        chk("t4_status", status, 2'b01);
        chk("t4_done_pulses", 64'(done_pulses - d0), 64'd1);

        // Error alone during the issue cycle.
        txn(32'h4000_0034, 32'h0000_00A5, 0, 1'b0, 1'b1);
        chk("t4b_status", status, 2'b01);

        // No response: timeout, then a late ack is ignored.
        txn(32'h4000_0040, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
        chk("t5_done_latency", 64'(last_done_cyc - acc_cyc), 64'd10);
        chk("t5_status", status, 2'b10);
        d0 = done_pulses;
        bif.bus_ack = 1'b1;
        tick();
        tick();
        bif.bus_ack = 1'b0;
        tick();
        chk("t5_late_ack_done", 64'(done_pulses - d0), 64'd0);
        chk("t5_late_ack_status", status, 2'b10);

        // Ack on the last count cycle beats the timeout.
        txn(32'h4000_0044, 32'h5555_AAAA, TIMEOUT, 1'b1, 1'b0);
        chk("t5b_done_latency", 64'(last_done_cyc - acc_cyc), 64'd10);
        chk("t5b_status", status, 2'b00);

        // Reset while waiting for ack drops the write silently.
        txn(32'h4000_0048, 32'h1111_2222, 0, 1'b0, 1'b0);
        acc_cyc       = cyc;
        done_cyc      = cyc + 2 + TIMEOUT;
        st_old        = st_new;
        st_new        = 2'b10;
        addr_old      = addr_new;
        data_old      = data_new;
        addr_new      = 32'h4000_0050;
        data_new      = 32'h7777_8888;
        bif.req_valid = 1'b1;
        bif.req_addr  = 32'h4000_0050;
        bif.req_data  = 32'h7777_8888;
        tick();
        bif.req_valid = 1'b0;
        repeat (3) tick();
        d0       = done_pulses;
        rst      = 1'b1;
        rst_from = cyc + 1;
        rst_to   = 1 << 30;
        acc_cyc  = -100;
        done_cyc = -100;
        st_old   = 2'b00;
        st_new   = 2'b00;
        addr_old = '0; addr_new = '0;
        data_old = '0; data_new = '0;
        tick();
        chk("t6_busy_after_rst", busy, 1'b0);
        chk("t6_status_after_rst", status, 2'b00);
        tick();
        rst    = 1'b0;
        rst_to = cyc;
        tick();
        chk("t6_no_done", 64'(done_pulses - d0), 64'd0);
        chk("t6_ready", bif.req_ready, 1'b1);
        txn(32'h4000_0060, 32'h0F0F_F0F0, 1, 1'b1, 1'b0);
        chk("t6_new_status", status, 2'b00);
        chk("t6_new_latency", 64'(last_done_cyc - acc_cyc), 64'd3);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
